// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the memory stage: datapath width, handshake FSM
// state encoding, wait counter width and the alignment helper.
package memory_access_stage_pkg;

    localparam int XLEN       = 64;
    localparam int WAIT_CNT_W = 8;

    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_t;

    // Only doubleword accesses exist, so any nonzero low address bit on a
    // memory op is a misaligned access.
    function automatic logic is_misaligned(input logic mem_op, input logic [2:0] byte_off);
        return mem_op & (byte_off != 3'd0);
    endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data memory request/acknowledge bus. The memory stage is the master and
// the data memory (or its model) is the slave.
interface memory_access_stage_if;
    import memory_access_stage_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );

endinterface

// File: rtl/memory_access_stage_dmem_handshake.sv
// Request/acknowledge sequencer for one data memory access. Raises req for
// an aligned memory op, waits for ack with a bounded wait counter, and tells
// the stage when the access completes, whether data was returned and whether
// it was abandoned. Request and stall are gated by reset so they drop the
// moment reset is asserted.
module dmem_handshake
    import memory_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_op,
    input  logic misaligned,
    input  logic ack,
    output logic req,
    output logic stall,
    output logic complete,
    output logic ack_taken,
    output logic timed_out
);

    localparam logic [WAIT_CNT_W-1:0] CNT_ZERO = {WAIT_CNT_W{1'b0}};
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

    mem_state_t            state_r;
    logic [WAIT_CNT_W-1:0] cnt_r;

    logic req_s;
    logic complete_s;
    logic ack_taken_s;
    logic timed_out_s;

    // Decode request, completion, data return and abandonment for this cycle.
    always_comb begin
        req_s       = 1'b0;
        complete_s  = 1'b0;
        ack_taken_s = 1'b0;
        timed_out_s = 1'b0;
        if (!reset) begin
            req_s = 1'b0;
        end else begin
            case (state_r)
                MEM_IDLE: begin
                    if (mem_op && misaligned) begin
                        complete_s = 1'b1;
                    end else if (mem_op) begin
                        req_s = 1'b1;
                        if (ack) begin
                            complete_s  = 1'b1;
                            ack_taken_s = 1'b1;
                        end else begin
                            complete_s = 1'b0;
                        end
                    end else begin
                        req_s = 1'b0;
                    end
                end
                MEM_BUSY: begin
                    req_s = 1'b1;
                    if (ack) begin
                        complete_s  = 1'b1;
                        ack_taken_s = 1'b1;
                    end else if (cnt_r == CNT_LAST) begin
                        complete_s  = 1'b1;
                        timed_out_s = 1'b1;
                    end else begin
                        complete_s = 1'b0;
                    end
                end
                default: begin
                    req_s = 1'b0;
                end
            endcase
        end
    end

    assign req       = req_s;
    assign stall     = req_s & ~complete_s;
    assign complete  = complete_s;
    assign ack_taken = ack_taken_s;
    assign timed_out = timed_out_s;

    // Track the outstanding access and count the cycles spent waiting for ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= MEM_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                MEM_IDLE: begin
                    if (req_s && !complete_s) begin
                        state_r <= MEM_BUSY;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        state_r <= MEM_IDLE;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                MEM_BUSY: begin
                    if (complete_s) begin
                        state_r <= MEM_IDLE;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= MEM_BUSY;
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= MEM_IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage of the RV64 pipeline: branch resolution, data memory access
// through the req/ack handshake, upstream stall, forwarding taps and the
// MEM/WB pipeline register with a sticky error flag.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XLEN-1:0]       Adderout,
    input  logic                  zero,
    input  logic [XLEN-1:0]       result_out_alu,
    input  logic [XLEN-1:0]       writedata_out,
    input  logic [4:0]            rd,
    input  logic                  Branch,
    input  logic                  Memread,
    input  logic                  Memtoreg,
    input  logic                  Memwrite,
    input  logic                  Regwrite,
    input  logic                  addermuxselect,
    output logic                  pcsrc,
    output logic [XLEN-1:0]       branch_target,
    output logic                  flush_out,
    output logic                  stall,
    memory_access_stage_if.master dmem,
    output logic [4:0]            fwd_rd,
    output logic                  fwd_regwrite,
    output logic [XLEN-1:0]       fwd_data,
    output logic [XLEN-1:0]       wb_readdata,
    output logic [XLEN-1:0]       wb_alu_result,
    output logic [4:0]            wb_rd,
    output logic                  wb_memtoreg,
    output logic                  wb_regwrite,
    output logic                  mem_err
);

    logic mem_op_s;
    logic misaligned_s;
    logic take_s;
    logic hs_req_s;
    logic hs_stall_s;
    logic hs_complete_s;
    logic hs_ack_taken_s;
    logic hs_timed_out_s;
    logic [XLEN-1:0] load_data_s;

    logic [XLEN-1:0] wb_readdata_r;
    logic [XLEN-1:0] wb_alu_result_r;
    logic [4:0]      wb_rd_r;
    logic            wb_memtoreg_r;
    logic            wb_regwrite_r;
    logic            mem_err_r;

    assign mem_op_s     = Memread | Memwrite;
    assign misaligned_s = is_misaligned(mem_op_s, result_out_alu[2:0]);

    // Jumps always redirect; conditional branches redirect on a zero result.
    assign take_s        = (Branch & zero) | addermuxselect;
    assign pcsrc         = take_s;
    assign flush_out     = take_s;
    assign branch_target = Adderout;

    dmem_handshake #(
        .TIMEOUT (TIMEOUT)
    ) u_dmem_handshake (
        .clk        (clk),
        .reset      (reset),
        .mem_op     (mem_op_s),
        .misaligned (misaligned_s),
        .ack        (dmem.dmem_ack),
        .req        (hs_req_s),
        .stall      (hs_stall_s),
        .complete   (hs_complete_s),
        .ack_taken  (hs_ack_taken_s),
        .timed_out  (hs_timed_out_s)
    );

    assign dmem.dmem_req   = hs_req_s;
    assign dmem.dmem_we    = Memwrite;
    assign dmem.dmem_addr  = result_out_alu;
    assign dmem.dmem_wdata = writedata_out;

    assign stall        = hs_stall_s;
    assign fwd_rd       = rd;
    assign fwd_regwrite = Regwrite & ~hs_stall_s;
    assign fwd_data     = result_out_alu;

    // Load data is only real when the memory acknowledged this load; an
    // abandoned or misaligned load writes back zero.
    always_comb begin
        load_data_s = {XLEN{1'b0}};
        if (Memread && hs_ack_taken_s && hs_complete_s) begin
            load_data_s = dmem.dmem_rdata;
        end else begin
            load_data_s = {XLEN{1'b0}};
        end
    end

    // MEM/WB register: bubble while stalled, otherwise capture the finished op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_readdata_r   <= {XLEN{1'b0}};
            wb_alu_result_r <= {XLEN{1'b0}};
            wb_rd_r         <= 5'd0;
            wb_memtoreg_r   <= 1'b0;
            wb_regwrite_r   <= 1'b0;
        end else if (hs_stall_s) begin
            wb_readdata_r   <= {XLEN{1'b0}};
            wb_alu_result_r <= {XLEN{1'b0}};
            wb_rd_r         <= 5'd0;
            wb_memtoreg_r   <= 1'b0;
            wb_regwrite_r   <= 1'b0;
        end else begin
            wb_readdata_r   <= load_data_s;
            wb_alu_result_r <= result_out_alu;
            wb_rd_r         <= rd;
            wb_memtoreg_r   <= Memtoreg;
            wb_regwrite_r   <= Regwrite & ~misaligned_s;
        end
    end

    // Sticky error: any misaligned access or abandoned access, cleared by reset only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_err_r <= 1'b0;
        end else if (misaligned_s || hs_timed_out_s) begin
            mem_err_r <= 1'b1;
        end else begin
            mem_err_r <= mem_err_r;
        end
    end

    assign wb_readdata   = wb_readdata_r;
    assign wb_alu_result = wb_alu_result_r;
    assign wb_rd         = wb_rd_r;
    assign wb_memtoreg   = wb_memtoreg_r;
    assign wb_regwrite   = wb_regwrite_r;
    assign mem_err       = mem_err_r;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios followed
// by randomized instructions, all checked every cycle against a
// transaction-level model of the memory stage.
module tb_memory_access_stage;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] Adderout, result_out_alu, writedata_out;
    logic        zero, Branch, Memread, Memtoreg, Memwrite, Regwrite, addermuxselect;
    logic [4:0]  rd;
    logic        pcsrc, flush_out, stall, fwd_regwrite, wb_memtoreg, wb_regwrite, mem_err;
    logic [63:0] branch_target, fwd_data, wb_readdata, wb_alu_result;
    logic [4:0]  fwd_rd, wb_rd;

    memory_access_stage_if dmem_bus();

    memory_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .Adderout(Adderout), .zero(zero),
        .result_out_alu(result_out_alu), .writedata_out(writedata_out), .rd(rd),
        .Branch(Branch), .Memread(Memread), .Memtoreg(Memtoreg), .Memwrite(Memwrite),
        .Regwrite(Regwrite), .addermuxselect(addermuxselect),
        .pcsrc(pcsrc), .branch_target(branch_target), .flush_out(flush_out), .stall(stall),
        .dmem(dmem_bus),
        .fwd_rd(fwd_rd), .fwd_regwrite(fwd_regwrite), .fwd_data(fwd_data),
        .wb_readdata(wb_readdata), .wb_alu_result(wb_alu_result), .wb_rd(wb_rd),
        .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // One instruction as presented by EX/MEM, plus the memory's behaviour:
    // d = cycles after the request at which ack arrives (NEVER = no ack).
    typedef struct {
        logic [63:0] adder, alu, wdata, rdv;
        logic [4:0]  rd;
        logic        br, zr, jmp, mr, mw, mtr, rw;
        int          d;
    } instr_t;

    int checks = 0;
    int failures = 0;

    instr_t cur;
    int     e;
    bit     chk_en = 1'b0;

    logic        exp_pcsrc, exp_req, exp_stall, exp_fwdrw;
    logic [63:0] exp_wb_rdata, exp_wb_alu;
    logic [4:0]  exp_wb_rd;
    logic        exp_wb_mtr, exp_wb_rw, exp_wb_bubble, exp_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pcsrc", {63'd0, pcsrc}, {63'd0, exp_pcsrc});
            chk("flush_out", {63'd0, flush_out}, {63'd0, exp_pcsrc});
            chk("branch_target", branch_target, cur.adder);
            chk("stall", {63'd0, stall}, {63'd0, exp_stall});
            chk("dmem_req", {63'd0, dmem_bus.dmem_req}, {63'd0, exp_req});
            chk("dmem_we", {63'd0, dmem_bus.dmem_we}, {63'd0, cur.mw});
            chk("dmem_addr", dmem_bus.dmem_addr, cur.alu);
            chk("dmem_wdata", dmem_bus.dmem_wdata, cur.wdata);
            chk("fwd_rd", {59'd0, fwd_rd}, {59'd0, cur.rd});
            chk("fwd_regwrite", {63'd0, fwd_regwrite}, {63'd0, exp_fwdrw});
            chk("fwd_data", fwd_data, cur.alu);
            chk("mem_err", {63'd0, mem_err}, {63'd0, exp_err});
            chk("wb_regwrite", {63'd0, wb_regwrite}, {63'd0, exp_wb_rw});
            chk("wb_memtoreg", {63'd0, wb_memtoreg}, {63'd0, exp_wb_mtr});
            if (!exp_wb_bubble) begin
                chk("wb_readdata", wb_readdata, exp_wb_rdata);
                chk("wb_alu_result", wb_alu_result, exp_wb_alu);
                chk("wb_rd", {59'd0, wb_rd}, {59'd0, exp_wb_rd});
            end
        end
    end

    function automatic instr_t rand_instr();
        instr_t t;
        int k;
        int dsel;
        k = int'($urandom_range(0, 9));
        dsel = int'($urandom_range(0, 9));
        t.adder = {$urandom, $urandom};
        t.alu   = {$urandom, $urandom};
        t.wdata = {$urandom, $urandom};
        t.rdv   = {$urandom, $urandom};
        t.rd    = 5'($urandom);
        t.mtr   = 1'($urandom);
        t.rw    = 1'($urandom);
        t.zr    = 1'($urandom);
        t.br = 1'b0; t.jmp = 1'b0; t.mr = 1'b0; t.mw = 1'b0;
        t.d = (dsel == 0) ? NEVER : (dsel == 1) ? TIMEOUT - 1 : int'($urandom_range(0, 5));
        case (k)
            0, 1, 2: begin t.mr = 1'b1; t.alu[2:0] = 3'd0; end
            3, 4:    begin t.mw = 1'b1; t.alu[2:0] = 3'd0; end
            5: begin
                if ($urandom_range(0, 1) == 0) t.mr = 1'b1; else t.mw = 1'b1;
                t.alu[2:0] = 3'($urandom_range(1, 7));
            end
            6: t.br = 1'b1;
            7: t.jmp = 1'b1;
            default: ;
        endcase
        return t;
    endfunction

    // One clock of the pipeline: drive the current instruction, predict the
    // outputs from the access rules, then commit the MEM/WB prediction.
    task automatic cycle(input bit rst_now, output bit stalled, output bit done);
        bit memop, aligned, live, timed, ackv;
        int c;
        logic [63:0] n_rdata, n_alu;
        logic [4:0]  n_rd;
        logic        n_mtr, n_rw, n_bubble, n_err;
        memop   = cur.mr | cur.mw;
        aligned = (cur.alu[2:0] == 3'd0);
        live    = memop && aligned && !rst_now;
        timed   = cur.d > TIMEOUT - 1;
        c       = timed ? TIMEOUT - 1 : cur.d;
        ackv    = memop ? (live && !timed && e == cur.d) : ($urandom_range(0, 3) == 0);

        reset = !rst_now;
        Adderout = cur.adder; zero = cur.zr; result_out_alu = cur.alu;
        writedata_out = cur.wdata; rd = cur.rd; Branch = cur.br;
        Memread = cur.mr; Memtoreg = cur.mtr; Memwrite = cur.mw;
        Regwrite = cur.rw; addermuxselect = cur.jmp;
        dmem_bus.dmem_ack   = ackv;
        dmem_bus.dmem_rdata = ackv && memop ? cur.rdv : {$urandom, $urandom};

        exp_pcsrc = (cur.br & cur.zr) | cur.jmp;
        exp_req   = live && e <= c;
        exp_stall = live && e < c;
        exp_fwdrw = cur.rw && !exp_stall;

        if (rst_now) begin
            exp_wb_rdata = 64'd0; exp_wb_alu = 64'd0; exp_wb_rd = 5'd0;
            exp_wb_mtr = 1'b0; exp_wb_rw = 1'b0; exp_wb_bubble = 1'b0; exp_err = 1'b0;
            n_rdata = 64'd0; n_alu = 64'd0; n_rd = 5'd0;
            n_mtr = 1'b0; n_rw = 1'b0; n_bubble = 1'b0; n_err = 1'b0;
        end else if (exp_stall) begin
            n_rdata = 64'd0; n_alu = 64'd0; n_rd = 5'd0;
            n_mtr = 1'b0; n_rw = 1'b0; n_bubble = 1'b1; n_err = exp_err;
        end else begin
            n_rdata  = (cur.mr && live && ackv) ? cur.rdv : 64'd0;
            n_alu    = cur.alu;
            n_rd     = cur.rd;
            n_mtr    = cur.mtr;
            n_rw     = cur.rw && !(memop && !aligned);
            n_bubble = 1'b0;
            n_err    = exp_err || (memop && !aligned) || (live && timed && e == c);
        end
        chk_en = 1'b1;
        #1;
        stalled = stall;
        @(posedge clk);
        #1;
        exp_wb_rdata = n_rdata; exp_wb_alu = n_alu; exp_wb_rd = n_rd;
        exp_wb_mtr = n_mtr; exp_wb_rw = n_rw; exp_wb_bubble = n_bubble; exp_err = n_err;
        done = rst_now || !exp_stall;
        e = done ? 0 : e + 1;
    endtask

    task automatic run_instr(input instr_t t, input bit allow_rst, output int stalls);
        bit s, fin;
        int guard;
        cur = t; e = 0; stalls = 0; fin = 1'b0; guard = 0;
        while (!fin && guard < 4 * TIMEOUT) begin
            cycle(allow_rst && ($urandom_range(0, 39) == 0), s, fin);
            if (s) stalls++;
            guard++;
        end
        if (!fin) chk("instr_cycle_budget", 64'd0, 64'd1);
    endtask

    initial begin
        instr_t t;
        int st;
        bit s, fin;

        reset = 1'b0;
        Adderout = 64'd0; zero = 1'b0; result_out_alu = 64'd0; writedata_out = 64'd0;
        rd = 5'd0; Branch = 1'b0; Memread = 1'b0; Memtoreg = 1'b0; Memwrite = 1'b0;
        Regwrite = 1'b0; addermuxselect = 1'b0;
        dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 64'd0;
        exp_wb_rdata = 64'd0; exp_wb_alu = 64'd0; exp_wb_rd = 5'd0;
        exp_wb_mtr = 1'b0; exp_wb_rw = 1'b0; exp_wb_bubble = 1'b0; exp_err = 1'b0;
        cur = rand_instr();

        // Reset state
        #12;
        chk("rst_wb_readdata", wb_readdata, 64'd0);
        chk("rst_wb_alu_result", wb_alu_result, 64'd0);
        chk("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
        chk("rst_wb_regwrite", {63'd0, wb_regwrite}, 64'd0);
        chk("rst_wb_memtoreg", {63'd0, wb_memtoreg}, 64'd0);
        chk("rst_mem_err", {63'd0, mem_err}, 64'd0);
        chk("rst_dmem_req", {63'd0, dmem_bus.dmem_req}, 64'd0);
        @(posedge clk); #1;

        // Load at 0x40 acknowledged in the request cycle
        t = rand_instr();
        t.br = 1'b0; t.jmp = 1'b0; t.mr = 1'b1; t.mw = 1'b0; t.rw = 1'b1;
        t.alu = 64'h40; t.d = 0; t.rdv = 64'hDEAD_BEEF;
        run_instr(t, 1'b0, st);
        chk("load0_stalls", 64'(st), 64'd0);
        chk("load0_rdata", wb_readdata, 64'hDEAD_BEEF);
        chk("load0_regwrite", {63'd0, wb_regwrite}, 64'd1);

        // Store at 0x80 acknowledged three cycles later
        t = rand_instr();
        t.br = 1'b0; t.jmp = 1'b0; t.mr = 1'b0; t.mw = 1'b1; t.rw = 1'b0;
        t.alu = 64'h80; t.d = 3;
        run_instr(t, 1'b0, st);
        chk("store3_stalls", 64'(st), 64'd3);
        chk("store3_we", {63'd0, dmem_bus.dmem_we}, 64'd1);

        // Taken and not-taken branch
        t = rand_instr();
        t.br = 1'b1; t.zr = 1'b1; t.jmp = 1'b0; t.mr = 1'b0; t.mw = 1'b0; t.adder = 64'h1000;
        run_instr(t, 1'b0, st);
        chk("br_taken_pcsrc", {63'd0, pcsrc}, 64'd1);
        chk("br_taken_flush", {63'd0, flush_out}, 64'd1);
        chk("br_taken_target", branch_target, 64'h1000);
        t.zr = 1'b0;
        run_instr(t, 1'b0, st);
        chk("br_not_taken_pcsrc", {63'd0, pcsrc}, 64'd0);

        // Load that never gets an ack
        t = rand_instr();
        t.br = 1'b0; t.jmp = 1'b0; t.mr = 1'b1; t.mw = 1'b0; t.alu = 64'h100; t.d = NEVER;
        run_instr(t, 1'b0, st);
        chk("timeout_stalls", 64'(st), 64'd15);
        chk("timeout_err", {63'd0, mem_err}, 64'd1);
        chk("timeout_rdata", wb_readdata, 64'd0);
        t = rand_instr();
        t.mr = 1'b0; t.mw = 1'b0;
        run_instr(t, 1'b0, st);
        chk("err_sticky", {63'd0, mem_err}, 64'd1);

        // Misaligned load at 0x43
        t = rand_instr();
        t.br = 1'b0; t.jmp = 1'b0; t.mr = 1'b1; t.mw = 1'b0; t.rw = 1'b1; t.alu = 64'h43;
        run_instr(t, 1'b0, st);
        chk("misal_stalls", 64'(st), 64'd0);
        chk("misal_req", {63'd0, dmem_bus.dmem_req}, 64'd0);
        chk("misal_regwrite", {63'd0, wb_regwrite}, 64'd0);
        chk("misal_err", {63'd0, mem_err}, 64'd1);

        // Reset while an access is waiting in BUSY
        t = rand_instr();
        t.br = 1'b0; t.jmp = 1'b0; t.mr = 1'b1; t.mw = 1'b0; t.alu = 64'h200; t.d = NEVER;
        cur = t; e = 0;
        repeat (3) cycle(1'b0, s, fin);
        reset = 1'b0;
        #1;
        chk("rstbusy_req", {63'd0, dmem_bus.dmem_req}, 64'd0);
        chk("rstbusy_stall", {63'd0, stall}, 64'd0);
        chk("rstbusy_wb_rw", {63'd0, wb_regwrite}, 64'd0);
        chk("rstbusy_wb_alu", wb_alu_result, 64'd0);
        cycle(1'b1, s, fin);
        chk("rstbusy_err_clear", {63'd0, mem_err}, 64'd0);
        t.d = 0;
        run_instr(t, 1'b0, st);
        chk("post_rst_idle_stalls", 64'(st), 64'd0);

        // Randomized instruction stream with occasional resets
        repeat (400) run_instr(rand_instr(), 1'b1, st);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
